mac_seq_ctrl: RTL and testbench
===============================

// Module: mac_seq_ctrl
// PURPOSE
//  Sequencer for one shared mac datapath instance in the MNIST inference engine.
//  Walks one layer: for each of N_OUT neurons it clears the accumulator, streams
//  N_IN (x, c) pairs from the input/weight memories into the mac, then presents
//  the result on a valid/ready output port. Sits between layer memories, mac and
//  the activation/argmax stage.
// PARAMETERS
//  W       4    data width of x, c and mac result (signed two's complement)
//  N_IN    784  inputs per neuron (>=1)
//  N_OUT   10   neurons in the layer (>=1)
//  XA_W    $clog2(N_IN)        input-memory address width (min 1)
//  WA_W    $clog2(N_IN*N_OUT)  weight-memory address width (min 1)
//  NI_W    $clog2(N_OUT)       neuron index width (min 1)
// PORTS
//  clk      in   1     single clock, all logic on rising edge
//  rst      in   1     synchronous, active-high reset
//  start    in   1     begin a layer pass; sampled only in IDLE
//  busy     out  1     high from the cycle after accepted start until done pulse
//  done     out  1     1-cycle pulse after the last result is accepted
//  rd_en    out  1     read strobe to input and weight memories (1-cycle latency)
//  x_addr   out  XA_W  input-memory address
//  w_addr   out  WA_W  weight-memory address
//  mac_clr  out  1     clears mac accumulator (ORed with rst at mac rst pin)
//  mac_en   out  1     accumulate enable: mac adds x*c this edge
//  mac_o    in   W     registered mac result
//  y_valid  out  1     result valid
//  y_ready  in   1     downstream accepts result
//  y_idx    out  NI_W  neuron index of y_data
//  y_data   out  W     captured mac result, signed
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, rd_en, mac_clr, mac_en, y_valid=0;
//   x_addr, w_addr, y_idx, y_data=0. rst mid-pass aborts with no done pulse.
//  FSM: IDLE -> CLR -> FETCH -> DRAIN -> CAPT -> EMIT -> (CLR | DONE) -> IDLE.
//   IDLE : start=1 -> CLR, neuron n=0, k=0, w_addr=0. start elsewhere ignored.
//   CLR  : mac_clr=1 for exactly 1 cycle -> FETCH.
//   FETCH: rd_en=1, x_addr=k, w_addr=n*N_IN+k, N_IN cycles (k=0..N_IN-1).
//          w_addr is a running counter, incremented by 1; no multiplier.
//   mac_en = rd_en delayed by 1 cycle (memory latency); exactly N_IN mac_en/neuron.
//   DRAIN: 1 cycle, carries final mac_en -> CAPT.
//   CAPT : y_data<=mac_o, y_idx<=n -> EMIT.
//   EMIT : y_valid=1, y_data/y_idx stable until y_valid&&y_ready; no rd_en/mac_en.
//          On handshake: n==N_OUT-1 -> DONE else n++, k=0 -> CLR.
//   DONE : done=1 one cycle, busy=0 that cycle -> IDLE.
//  Per-neuron latency with y_ready tied high: N_IN+4 cycles (CLR..EMIT).
//  y_ready stalls arbitrarily long with no state change; y_ready ignored outside EMIT.
//  start high in DONE is ignored; a new pass needs start in IDLE.
//  N_IN=1: FETCH lasts 1 cycle. N_OUT=1: single EMIT then DONE.
//  No arithmetic in controller; width/wrap of result is owned by mac.
// STRUCTURE
//  Package nn_ctrl_pkg: state_t enum (IDLE,CLR,FETCH,DRAIN,CAPT,EMIT,DONE),
//   W default, layer-size localparams shared with memories.
//  Sub-module mac_addr_gen: k/n/w_addr counters with clear/step/last flags;
//   FSM, mac_en delay and output register stay in mac_seq_ctrl.
// TESTING (bench: W=4, N_IN=3, N_OUT=2, real mac + behavioural 1-cycle memories)
//  1 x={4,6,-4}, c0={-3,-1,-3}, c1={1,1,1}, y_ready=1, start pulse ->
//    y(idx0)=-6 (4'b1010), y(idx1)=6; done pulse; exactly 6 mac_en, 2 mac_clr.
//  2 Same, y_ready low 5 cycles in each EMIT -> y_valid held, y_data/y_idx stable,
//    no rd_en/mac_en during stall, results unchanged.
//  3 Check addresses: w_addr sequence 0,1,2 then 3,4,5; x_addr 0,1,2 twice;
//    neuron 0 latency start->y_valid = 1+N_IN+4 = 8 cycles.
//  4 rst asserted in FETCH of neuron 1 -> next cycle all outputs 0, IDLE, no done;
//    new start gives results identical to test 1.
//  5 start held high through whole pass and during DONE -> only one pass,
//    one done pulse; start pulse while busy ignored.
//  6 N_IN=1, N_OUT=1, x=-8, c=1 -> y_data=-8, FETCH 1 cycle, done after handshake.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared types and layer sizes for the MNIST inference controllers.
// Memories and sequencers pull their geometry from here.
package nn_ctrl_pkg;

  localparam int W_DEF     = 4;
  localparam int N_IN_DEF  = 784;
  localparam int N_OUT_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FETCH,
    DRAIN,
    CAPT,
    EMIT,
    DONE
  } state_t;

  // address width for a depth of n, never below one bit
  function automatic int aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_addr_gen.sv
// Input/neuron/weight counters for the mac sequencer.
// w_addr runs linearly across neurons, so no n*N_IN product is needed.
module mac_addr_gen
  import nn_ctrl_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int XA_W  = aw(N_IN),
  parameter int WA_W  = aw(N_IN * N_OUT),
  parameter int NI_W  = aw(N_OUT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            step,
  input  logic            next,
  output logic [XA_W-1:0] k,
  output logic [NI_W-1:0] n,
  output logic [WA_W-1:0] w_addr,
  output logic            k_last,
  output logic            n_last
);

  localparam logic [XA_W-1:0] K_MAX = XA_W'(N_IN - 1);
  localparam logic [NI_W-1:0] N_MAX = NI_W'(N_OUT - 1);

  assign k_last = (k == K_MAX);
  assign n_last = (n == N_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      k      <= '0;
      n      <= '0;
      w_addr <= '0;
    end else begin
      if (step) begin
        k <= k_last ? '0 : k + 1'b1;
        // hold on the very last weight so the counter never overruns
        if (!(k_last && n_last))
          w_addr <= w_addr + 1'b1;
      end
      if (next) begin
        n <= n + 1'b1;
        k <= '0;
      end
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Layer sequencer: clears, feeds and drains one shared mac per neuron,
// then offers each result on a valid/ready port.
module mac_seq_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int XA_W  = aw(N_IN),
  parameter int WA_W  = aw(N_IN * N_OUT),
  parameter int NI_W  = aw(N_OUT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [XA_W-1:0] x_addr,
  output logic [WA_W-1:0] w_addr,
  output logic            mac_clr,
  output logic            mac_en,
  input  logic [W-1:0]    mac_o,
  output logic            y_valid,
  input  logic            y_ready,
  output logic [NI_W-1:0] y_idx,
  output logic [W-1:0]    y_data
);

  state_t state, state_nx;

  logic            ag_clr;
  logic            ag_step;
  logic            ag_next;
  logic            cap;
  logic            k_last;
  logic            n_last;
  logic [NI_W-1:0] n;

  mac_addr_gen #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .XA_W  (XA_W),
    .WA_W  (WA_W),
    .NI_W  (NI_W)
  ) u_ag (
    .clk    (clk),
    .rst    (rst),
    .clr    (ag_clr),
    .step   (ag_step),
    .next   (ag_next),
    .k      (x_addr),
    .n      (n),
    .w_addr (w_addr),
    .k_last (k_last),
    .n_last (n_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    mac_clr  = 1'b0;
    y_valid  = 1'b0;
    ag_clr   = 1'b0;
    ag_step  = 1'b0;
    ag_next  = 1'b0;
    cap      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          ag_clr   = 1'b1;
          state_nx = CLR;
        end
      end
      CLR: begin
        busy     = 1'b1;
        mac_clr  = 1'b1;
        state_nx = FETCH;
      end
      FETCH: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        ag_step = 1'b1;
        if (k_last) state_nx = DRAIN;
      end
      DRAIN: begin
        busy     = 1'b1;
        state_nx = CAPT;
      end
      CAPT: begin
        busy     = 1'b1;
        cap      = 1'b1;
        state_nx = EMIT;
      end
      EMIT: begin
        busy    = 1'b1;
        y_valid = 1'b1;
        if (y_ready) begin
          if (n_last) begin
            state_nx = DONE;
          end else begin
            ag_next  = 1'b1;
            state_nx = CLR;
          end
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // memory read data arrives one cycle after rd_en
  always_ff @(posedge clk) begin
    if (rst) mac_en <= 1'b0;
    else     mac_en <= rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_data <= '0;
      y_idx  <= '0;
    end else if (cap) begin
      y_data <= mac_o;
      y_idx  <= n;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench: two controller instances with a behavioural mac and
// 1-cycle memories (3x2 layer and 1x1 layer).
module tb_mac_seq_ctrl;

  logic clk = 0;
  always #5 clk = ~clk;

  logic rst = 1;

  // instance A: N_IN=3, N_OUT=2
  logic       a_start = 0, a_busy, a_done, a_rd_en, a_mac_clr, a_mac_en;
  logic [1:0] a_x_addr;
  logic [2:0] a_w_addr;
  logic [3:0] a_mac_o, a_y_data;
  logic       a_y_valid, a_y_ready = 1;
  logic [0:0] a_y_idx;

  mac_seq_ctrl #(.W(4), .N_IN(3), .N_OUT(2)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .x_addr(a_x_addr), .w_addr(a_w_addr),
    .mac_clr(a_mac_clr), .mac_en(a_mac_en), .mac_o(a_mac_o),
    .y_valid(a_y_valid), .y_ready(a_y_ready), .y_idx(a_y_idx),
    .y_data(a_y_data)
  );

  logic signed [3:0] axm [3];
  logic signed [3:0] awm [6];
  logic signed [3:0] axd, awd, aacc;
  always @(posedge clk) if (a_rd_en) begin
    axd <= axm[a_x_addr];
    awd <= awm[a_w_addr];
  end
  always @(posedge clk)
    if (rst || a_mac_clr) aacc <= 0;
    else if (a_mac_en)    aacc <= aacc + axd * awd;
  assign a_mac_o = aacc;

  // instance B: N_IN=1, N_OUT=1
  logic       b_start = 0, b_busy, b_done, b_rd_en, b_mac_clr, b_mac_en;
  logic [0:0] b_x_addr, b_w_addr, b_y_idx;
  logic [3:0] b_mac_o, b_y_data;
  logic       b_y_valid, b_y_ready = 1;

  mac_seq_ctrl #(.W(4), .N_IN(1), .N_OUT(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .x_addr(b_x_addr), .w_addr(b_w_addr),
    .mac_clr(b_mac_clr), .mac_en(b_mac_en), .mac_o(b_mac_o),
    .y_valid(b_y_valid), .y_ready(b_y_ready), .y_idx(b_y_idx),
    .y_data(b_y_data)
  );

  logic signed [3:0] bxd, bwd, bacc;
  always @(posedge clk) if (b_rd_en) begin
    bxd <= -4'sd8;
    bwd <= 4'sd1;
  end
  always @(posedge clk)
    if (rst || b_mac_clr) bacc <= 0;
    else if (b_mac_en)    bacc <= bacc + bxd * bwd;
  assign b_mac_o = bacc;

  int errs = 0, checks = 0;
  int n_en, n_clr, n_done, emit_bad, b_rd;
  int wseq[$], xseq[$];

  always @(negedge clk) begin
    if (a_mac_en)  n_en++;
    if (a_mac_clr) n_clr++;
    if (a_done)    n_done++;
    if (a_rd_en) begin
      wseq.push_back(int'(a_w_addr));
      xseq.push_back(int'(a_x_addr));
    end
    if (a_y_valid && (a_rd_en || a_mac_en)) emit_bad++;
    if (b_rd_en) b_rd++;
  end

  logic [3:0] ya [2];
  logic [0:0] ia [2];
  int  lat0, stall_bad;
  logic busy_at_done;

  task automatic clear_mon();
    n_en = 0; n_clr = 0; n_done = 0; emit_bad = 0; stall_bad = 0;
    wseq.delete(); xseq.delete();
  endtask

  task automatic run_a(input int stall, input bit hold, output bit to);
    int cyc, b;
    to = 0;
    @(negedge clk);
    a_start = 1;
    cyc = 1;
    for (int nn = 0; nn < 2; nn++) begin
      b = 0;
      while (!a_y_valid && b < 50) begin
        @(negedge clk);
        cyc++; b++;
        if (!hold) a_start = 0;
      end
      if (b >= 50) begin to = 1; a_start = 0; return; end
      if (nn == 0) lat0 = cyc;
      ya[nn] = a_y_data;
      ia[nn] = a_y_idx;
      if (stall > 0) begin
        a_y_ready = 0;
        repeat (stall) begin
          @(negedge clk);
          if (!a_y_valid || a_y_data !== ya[nn] || a_y_idx !== ia[nn])
            stall_bad++;
        end
        a_y_ready = 1;
      end
      @(negedge clk);
    end
    b = 0;
    while (!a_done && b < 20) begin @(negedge clk); b++; end
    if (b >= 20) to = 1;
    busy_at_done = a_busy;
    @(negedge clk);
    a_start = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_rd_en, a_mac_clr, a_mac_en, a_y_valid,
         a_x_addr, a_w_addr, a_y_idx, a_y_data} !== '0) begin
      errs++;
      $display("FAIL reset_a: got busy=%b done=%b rd=%b clr=%b en=%b v=%b xa=%0d wa=%0d idx=%0d y=%0d, want all 0",
               a_busy, a_done, a_rd_en, a_mac_clr, a_mac_en, a_y_valid,
               a_x_addr, a_w_addr, a_y_idx, a_y_data);
    end
    checks++;
    if ({b_busy, b_done, b_rd_en, b_mac_clr, b_mac_en, b_y_valid,
         b_x_addr, b_w_addr, b_y_idx, b_y_data} !== '0) begin
      errs++;
      $display("FAIL reset_b: some output nonzero, want all 0");
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    clear_mon();
    run_a(0, 0, to);
    checks++;
    if (to !== 0) begin errs++; $display("FAIL basic_timeout: got 1 want 0"); end
    checks++;
    if (ya[0] !== 4'b1010 || ia[0] !== 1'b0) begin
      errs++; $display("FAIL basic_y0: got %b idx %0d want 1010 idx 0", ya[0], ia[0]);
    end
    checks++;
    if (ya[1] !== 4'b0110 || ia[1] !== 1'b1) begin
      errs++; $display("FAIL basic_y1: got %b idx %0d want 0110 idx 1", ya[1], ia[1]);
    end
    checks++;
    if (n_done !== 1 || busy_at_done !== 1'b0) begin
      errs++; $display("FAIL basic_done: got %0d pulses busy=%b want 1 busy=0", n_done, busy_at_done);
    end
    checks++;
    if (n_en !== 6 || n_clr !== 2) begin
      errs++; $display("FAIL basic_counts: got en=%0d clr=%0d want en=6 clr=2", n_en, n_clr);
    end
  endtask

  task automatic test_stall();
    bit to;
    clear_mon();
    run_a(5, 0, to);
    checks++;
    if (to !== 0 || ya[0] !== 4'b1010 || ya[1] !== 4'b0110) begin
      errs++; $display("FAIL stall_result: got to=%b y0=%b y1=%b want 0 1010 0110", to, ya[0], ya[1]);
    end
    checks++;
    if (stall_bad !== 0 || emit_bad !== 0) begin
      errs++; $display("FAIL stall_hold: got unstable=%0d emit_activity=%0d want 0 0", stall_bad, emit_bad);
    end
    checks++;
    if (n_en !== 6 || n_done !== 1) begin
      errs++; $display("FAIL stall_counts: got en=%0d done=%0d want 6 1", n_en, n_done);
    end
  endtask

  task automatic test_addr();
    bit to;
    int wexp[6] = '{0, 1, 2, 3, 4, 5};
    int xexp[6] = '{0, 1, 2, 0, 1, 2};
    int bad = 0;
    clear_mon();
    run_a(0, 0, to);
    if (wseq.size() != 6 || xseq.size() != 6) bad = 1;
    else for (int i = 0; i < 6; i++)
      if (wseq[i] != wexp[i] || xseq[i] != xexp[i]) bad = 1;
    checks++;
    if (bad != 0) begin
      errs++; $display("FAIL addr_seq: got w=%p x=%p want w=%p x=%p", wseq, xseq, wexp, xexp);
    end
    checks++;
    if (lat0 !== 8) begin
      errs++; $display("FAIL latency: got %0d want 8", lat0);
    end
  endtask

  task automatic test_abort();
    bit to;
    int b = 0;
    clear_mon();
    @(negedge clk);
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    while (!(a_rd_en && a_w_addr == 3'd4) && b < 50) begin @(negedge clk); b++; end
    checks++;
    if (b >= 50) begin errs++; $display("FAIL abort_reach: got timeout want neuron1 fetch"); end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_rd_en, a_mac_clr, a_mac_en, a_y_valid,
         a_x_addr, a_w_addr, a_y_idx, a_y_data} !== '0) begin
      errs++; $display("FAIL abort_zero: got busy=%b rd=%b en=%b xa=%0d wa=%0d y=%0d want 0",
                       a_busy, a_rd_en, a_mac_en, a_x_addr, a_w_addr, a_y_data);
    end
    rst = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (n_done !== 0 || a_busy !== 1'b0) begin
      errs++; $display("FAIL abort_nodone: got done=%0d busy=%b want 0 0", n_done, a_busy);
    end
    run_a(0, 0, to);
    checks++;
    if (to !== 0 || ya[0] !== 4'b1010 || ya[1] !== 4'b0110) begin
      errs++; $display("FAIL abort_rerun: got y0=%b y1=%b want 1010 0110", ya[0], ya[1]);
    end
  endtask

  task automatic test_start_held();
    bit to;
    clear_mon();
    run_a(2, 1, to);
    repeat (4) @(negedge clk);
    checks++;
    if (to !== 0 || n_done !== 1 || n_en !== 6 || n_clr !== 2) begin
      errs++; $display("FAIL start_held: got done=%0d en=%0d clr=%0d want 1 6 2", n_done, n_en, n_clr);
    end
    checks++;
    if (a_busy !== 1'b0) begin
      errs++; $display("FAIL start_held_idle: got busy=%b want 0", a_busy);
    end
  endtask

  task automatic test_single();
    int b = 0;
    b_rd = 0;
    @(negedge clk);
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    while (!b_y_valid && b < 20) begin @(negedge clk); b++; end
    checks++;
    if (b_y_valid !== 1'b1 || b_y_data !== 4'b1000 || b_y_idx !== 1'b0) begin
      errs++; $display("FAIL single_y: got v=%b y=%b idx=%0d want 1 1000 0", b_y_valid, b_y_data, b_y_idx);
    end
    checks++;
    if (b_rd !== 1) begin
      errs++; $display("FAIL single_fetch: got %0d rd cycles want 1", b_rd);
    end
    @(negedge clk);
    checks++;
    if (b_done !== 1'b1 || b_busy !== 1'b0) begin
      errs++; $display("FAIL single_done: got done=%b busy=%b want 1 0", b_done, b_busy);
    end
  endtask

  initial begin
    axm[0] = 4; axm[1] = 6; axm[2] = -4;
    awm[0] = -3; awm[1] = -1; awm[2] = -3;
    awm[3] = 1;  awm[4] = 1;  awm[5] = 1;
    test_reset();
    test_basic();
    test_stall();
    test_addr();
    test_abort();
    test_start_held();
    test_single();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
